shared_sp_ram: RTL and testbench

Parametrised single-port RAM shared by `NUM_PORTS` requestors through a round-robin arbiter, speaking the core's req/gnt/rvalid memory protocol on every port. It replaces the per-interface private RAMs in the SoC: instruction fetch and data ports of one or more cores attach to one instance. Unlike the earlier RAM it returns a bus error for out-of-range addresses, so the core's `*_err_i` inputs are driven.

---
 rtl/shared_sp_ram_if.sv | 29 ++
 rtl/shared_sp_ram.sv | 147 ++++++++++++++
 tb/tb_shared_sp_ram.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/shared_sp_ram_if.sv
// Request/response bus between the requestor ports and shared_sp_ram.
// Every signal is a flat vector with one slice per port; port k occupies slice k.
interface shared_sp_ram_if #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [NUM_PORTS-1:0]                  req_i;
  logic [NUM_PORTS-1:0]                  gnt_o;
  logic [NUM_PORTS*ADDR_WIDTH-1:0]       addr_i;
  logic [NUM_PORTS-1:0]                  we_i;
  logic [NUM_PORTS*(DATA_WIDTH/8)-1:0]   be_i;
  logic [NUM_PORTS*DATA_WIDTH-1:0]       wdata_i;
  logic [NUM_PORTS-1:0]                  rvalid_o;
  logic [NUM_PORTS-1:0]                  err_o;
  logic [NUM_PORTS*DATA_WIDTH-1:0]       rdata_o;

  // Requestor side.
  modport master (
    output req_i, addr_i, we_i, be_i, wdata_i,
    input  gnt_o, rvalid_o, err_o, rdata_o
  );

  // Memory side.
  modport slave (
    input  req_i, addr_i, we_i, be_i, wdata_i,
    output gnt_o, rvalid_o, err_o, rdata_o
  );
endinterface

// File: rtl/shared_sp_ram.sv
// Single-port RAM shared by NUM_PORTS requestors through a round-robin arbiter.
// One access per cycle; each accepted request gets exactly one response one
// cycle later. Out-of-range addresses return err=1, rdata=0 and never write.
module shared_sp_ram #(
  parameter int                    NUM_PORTS  = 2,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_WORDS  = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  shared_sp_ram_if.slave  bus
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int BOFF  = (BYTES > 1) ? $clog2(BYTES) : 0;
  localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  // Size of the decoded window in bytes; one extra bit so the compare cannot wrap.
  localparam logic [ADDR_WIDTH:0] SPAN = (ADDR_WIDTH+1)'(NUM_WORDS * BYTES);

  // Arbiter state and outputs
  logic [PTR_W-1:0]      ptr_reg;
  logic [PTR_W-1:0]      ptr_next;
  logic [PTR_W-1:0]      sel;
  logic                  any_gnt;
  logic [NUM_PORTS-1:0]  gnt;

  // Muxed access of the granted port
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [ADDR_WIDTH-1:0] offset;
  logic                  acc_we;
  logic [BYTES-1:0]      acc_be;
  logic [DATA_WIDTH-1:0] acc_wdata;
  logic                  in_range;
  logic [IDX_W-1:0]      word_idx;
  logic                  ram_wr;
  logic                  ram_rd;

  // Storage and its registered read port
  logic [DATA_WIDTH-1:0] mem [NUM_WORDS];
  logic [DATA_WIDTH-1:0] rd_word_reg;

  // Round-robin scan: first requesting port at distance 0,1,.. from ptr wins.
  always_comb begin
    gnt     = '0;
    sel     = '0;
    any_gnt = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      for (int k = 0; k < NUM_PORTS; k++) begin
        if (!any_gnt && bus.req_i[k] && (((int'(ptr_reg) + i) % NUM_PORTS) == k)) begin
          gnt[k]  = 1'b1;
          sel     = PTR_W'(k);
          any_gnt = 1'b1;
        end
      end
    end
  end

  assign bus.gnt_o = gnt;
  // Pointer moves just past the winner; with one port this is always zero.
  assign ptr_next  = (sel == PTR_W'(NUM_PORTS - 1)) ? '0 : sel + 1'b1;

  // Priority pointer advances only on a grant.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_reg <= '0;
    end else if (any_gnt) begin
      ptr_reg <= ptr_next;
    end
  end

  // Select the granted port's request fields (one-hot gnt, so OR-mux is safe).
  always_comb begin
    acc_addr  = '0;
    acc_we    = 1'b0;
    acc_be    = '0;
    acc_wdata = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (gnt[k]) begin
        acc_addr  = bus.addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
        acc_we    = bus.we_i[k];
        acc_be    = bus.be_i[k*BYTES +: BYTES];
        acc_wdata = bus.wdata_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign offset   = acc_addr - BASE_ADDR;
  assign in_range = (acc_addr >= BASE_ADDR) && ({1'b0, offset} < SPAN);
  assign word_idx = offset[BOFF +: IDX_W];
  assign ram_wr   = any_gnt && acc_we && in_range;
  assign ram_rd   = any_gnt && !acc_we && in_range;

  // RAM: byte-masked write and registered read, no reset so it maps to block RAM.
  always_ff @(posedge clk_i) begin
    if (ram_wr) begin
      for (int b = 0; b < BYTES; b++) begin
        if (acc_be[b]) begin
          mem[word_idx][b*8 +: 8] <= acc_wdata[b*8 +: 8];
        end
      end
    end
    if (ram_rd) begin
      rd_word_reg <= mem[word_idx];
    end
  end

  // Per-port response path. During the valid cycle of an in-range read the
  // shared RAM output is shown; otherwise a per-port hold register supplies
  // the last response data (zero for writes and errors).
  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
    logic                  rvalid_reg;
    logic                  err_reg;
    logic                  rd_hit_reg;
    logic [DATA_WIDTH-1:0] hold_reg;
    logic [DATA_WIDTH-1:0] rdata_w;

    assign rdata_w = (rvalid_reg && rd_hit_reg) ? rd_word_reg : hold_reg;

    // Capture response kind on accept; latch the shown data after its valid cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        rvalid_reg <= 1'b0;
        err_reg    <= 1'b0;
        rd_hit_reg <= 1'b0;
        hold_reg   <= '0;
      end else begin
        rvalid_reg <= gnt[gi];
        if (gnt[gi]) begin
          err_reg    <= !in_range;
          rd_hit_reg <= ram_rd;
          hold_reg   <= '0;
        end else if (rvalid_reg) begin
          rd_hit_reg <= 1'b0;
          hold_reg   <= rdata_w;
        end
      end
    end

    assign bus.rvalid_o[gi]                         = rvalid_reg;
    assign bus.err_o[gi]                            = err_reg;
    assign bus.rdata_o[gi*DATA_WIDTH +: DATA_WIDTH] = rdata_w;
  end

endmodule

// File: tb/tb_shared_sp_ram.sv
// Bench for shared_sp_ram with three ports: table-driven single accesses plus
// hand-written round-robin, read-after-write and reset-abort sequences.
// Responses are checked against a queue of expectations pushed at grant time.
module tb_shared_sp_ram;

  localparam int NP = 3;

  logic clk;
  logic rst;
  int   cyc;
  int   tests;
  int   failed;

  shared_sp_ram_if #(.NUM_PORTS(NP), .ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  shared_sp_ram #(
    .NUM_PORTS(NP), .ADDR_WIDTH(32), .DATA_WIDTH(32),
    .NUM_WORDS(256), .BASE_ADDR(32'h0)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  typedef struct {
    int          port;
    bit          we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    bit          exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  typedef struct {
    int          port;
    int          due;
    bit          err;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int p, input bit we, input logic [31:0] a,
                              input logic [3:0] be, input logic [31:0] wd,
                              input bit xerr, input logic [31:0] xrd);
    vec_t v;
    v.port = p; v.we = we; v.addr = a; v.be = be; v.wdata = wd;
    v.exp_err = xerr; v.exp_rdata = xrd;
    return v;
  endfunction

  task automatic push_exp(input int p, input bit err, input logic [31:0] rd);
    exp_t e;
    e.port = p; e.due = cyc + 1; e.err = err; e.rdata = rd;
    sb.push_back(e);
  endtask

  task automatic set_port(input int p, input bit we, input logic [31:0] a,
                          input logic [3:0] be, input logic [31:0] wd);
    bus.we_i[p]            = we;
    bus.addr_i[p*32 +: 32] = a;
    bus.be_i[p*4 +: 4]     = be;
    bus.wdata_i[p*32 +: 32] = wd;
  endtask

  // Single-requestor access: must be granted in its request cycle.
  task automatic do_access(input vec_t v, input int n);
    int waited;
    bit granted;
    @(posedge clk); #1;
    set_port(v.port, v.we, v.addr, v.be, v.wdata);
    bus.req_i[v.port] = 1'b1;
    granted = 1'b0;
    waited  = 0;
    while (!granted && waited < 20) begin
      @(negedge clk);
      if (bus.gnt_o[v.port]) begin
        granted = 1'b1;
        push_exp(v.port, v.exp_err, v.exp_rdata);
      end else begin
        waited++;
      end
    end
    chk($sformatf("vec%0d gnt_wait", n), 32'(waited), 32'd0);
    @(posedge clk); #1;
    bus.req_i[v.port] = 1'b0;
  endtask

  // Response monitor: every rvalid must match the oldest expectation, on time.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        sb.delete();
      end else begin
        while (sb.size() > 0 && sb[0].due < cyc) begin
          e = sb.pop_front();
          tests++; failed++;
          $display("FAIL missing_rvalid: port %0d got none expected rvalid at cycle %0d", e.port, e.due);
        end
        for (int k = 0; k < NP; k++) begin
          if (bus.rvalid_o[k]) begin
            if (sb.size() == 0 || sb[0].due != cyc || sb[0].port != k) begin
              tests++; failed++;
              $display("FAIL unexpected_rvalid: port %0d got rvalid at cycle %0d expected none", k, cyc);
            end else begin
              e = sb.pop_front();
              $display("[TB] cycle %0d port %0d resp err=%0d rdata=%h", cyc, k, bus.err_o[k], bus.rdata_o[k*32 +: 32]);
              chk($sformatf("p%0d err", k), 32'(bus.err_o[k]), 32'(e.err));
              chk($sformatf("p%0d rdata", k), bus.rdata_o[k*32 +: 32], e.rdata);
            end
          end
        end
      end
    end
  end

  initial begin
    logic [2:0] exp_g;
    tests  = 0;
    failed = 0;
    cyc    = 0;
    rst    = 1'b1;
    bus.req_i   = '0;
    bus.we_i    = '0;
    bus.addr_i  = '0;
    bus.be_i    = '0;
    bus.wdata_i = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset rvalid", 32'(bus.rvalid_o), 32'd0);
    chk("reset err", 32'(bus.err_o), 32'd0);
    for (int k = 0; k < NP; k++) chk($sformatf("reset rdata%0d", k), bus.rdata_o[k*32 +: 32], 32'd0);
    chk("reset gnt idle", 32'(bus.gnt_o), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Table of single accesses
    vecs.push_back(mk(0, 1, 32'h10,  4'hF, 32'hDEADBEEF, 0, 32'h0));
    vecs.push_back(mk(0, 0, 32'h10,  4'h0, 32'h0,        0, 32'hDEADBEEF));
    vecs.push_back(mk(1, 1, 32'h20,  4'hF, 32'h11223344, 0, 32'h0));
    vecs.push_back(mk(2, 1, 32'h20,  4'h5, 32'hAABBCCDD, 0, 32'h0));
    vecs.push_back(mk(0, 0, 32'h20,  4'h0, 32'h0,        0, 32'h11BB33DD));
    vecs.push_back(mk(1, 1, 32'h0,   4'hF, 32'hCAFEF00D, 0, 32'h0));
    vecs.push_back(mk(2, 0, 32'h400, 4'h0, 32'h0,        1, 32'h0));
    vecs.push_back(mk(2, 1, 32'h400, 4'hF, 32'hFFFFFFFF, 1, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0,   4'h0, 32'h0,        0, 32'hCAFEF00D));
    vecs.push_back(mk(1, 1, 32'h3FC, 4'hF, 32'h01020304, 0, 32'h0));
    vecs.push_back(mk(1, 1, 32'h3FC, 4'h0, 32'hFFFFFFFF, 0, 32'h0));
    vecs.push_back(mk(2, 0, 32'h3FD, 4'h0, 32'h0,        0, 32'h01020304));
    vecs.push_back(mk(1, 0, 32'h13,  4'h0, 32'h0,        0, 32'hDEADBEEF));
    vecs.push_back(mk(2, 0, 32'hFFFFFFFC, 4'h0, 32'h0,   1, 32'h0));
    vecs.push_back(mk(0, 0, 32'h10,  4'h0, 32'h0,        0, 32'hDEADBEEF));
    for (int i = 0; i < vecs.size(); i++) do_access(vecs[i], i);

    // Response data holds after the valid cycle
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("hold p0 rdata", bus.rdata_o[31:0], 32'hDEADBEEF);
    chk("hold p2 err", 32'(bus.err_o[2]), 32'd1);

    // Read-after-write across ports in consecutive cycles
    @(posedge clk); #1;
    set_port(1, 1'b1, 32'h40, 4'hF, 32'h5A5A5A5A);
    bus.req_i = 3'b010;
    @(negedge clk);
    chk("raw gnt p1", 32'(bus.gnt_o), 32'b010);
    push_exp(1, 1'b0, 32'h0);
    @(posedge clk); #1;
    set_port(0, 1'b0, 32'h40, 4'h0, 32'h0);
    bus.req_i = 3'b001;
    @(negedge clk);
    chk("raw gnt p0", 32'(bus.gnt_o), 32'b001);
    push_exp(0, 1'b0, 32'h5A5A5A5A);
    @(posedge clk); #1;
    bus.req_i = '0;
    repeat (3) @(posedge clk);

    // Round-robin from reset, all three ports requesting for six cycles
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    set_port(0, 1'b0, 32'h10,  4'h0, 32'h0);
    set_port(1, 1'b0, 32'h20,  4'h0, 32'h0);
    set_port(2, 1'b0, 32'h400, 4'h0, 32'h0);
    bus.req_i = 3'b111;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      exp_g = 3'b001 << (i % 3);
      chk($sformatf("rr gnt%0d", i), 32'(bus.gnt_o), 32'(exp_g));
      case (i % 3)
        0: push_exp(0, 1'b0, 32'hDEADBEEF);
        1: push_exp(1, 1'b0, 32'h11BB33DD);
        default: push_exp(2, 1'b1, 32'h0);
      endcase
    end
    @(posedge clk); #1;
    bus.req_i = '0;
    repeat (3) @(posedge clk);

    // Reset while a read response is pending; ptr is left at 1 beforehand
    #1;
    bus.req_i = 3'b001;
    @(negedge clk);
    chk("abort gnt p0", 32'(bus.gnt_o), 32'b001);
    @(posedge clk); #1;
    bus.req_i = '0;
    rst = 1'b1;
    #1;
    chk("abort rvalid", 32'(bus.rvalid_o), 32'd0);
    chk("abort err", 32'(bus.err_o), 32'd0);
    for (int k = 0; k < NP; k++) chk($sformatf("abort rdata%0d", k), bus.rdata_o[k*32 +: 32], 32'd0);
    bus.req_i = 3'b111;
    #1;
    chk("abort ptr0 gnt", 32'(bus.gnt_o), 32'b001);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post-reset gnt", 32'(bus.gnt_o), 32'b001);
    push_exp(0, 1'b0, 32'hDEADBEEF);
    @(posedge clk); #1;
    bus.req_i = '0;

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("scoreboard drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
